// File: rtl/capture_rd_pkg.sv
// Shared constants and state encoding for the capture SRAM readback engine.
package capture_rd_pkg;

  localparam int NUM_PATH_DEF  = 96;
  localparam int SAMPLE_W_DEF  = 9;
  localparam int ADDR_W_DEF    = 15;
  localparam int MEM_DEPTH_DEF = 32768;
  localparam int CNT_W         = 3;
  localparam int SEL_W         = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/capture_lane_mux.sv
// Registered NUM_PATH:1 lane selector with load enable.
module capture_lane_mux
  import capture_rd_pkg::*;
#(
  parameter int NUM_PATH = NUM_PATH_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_PATH*SAMPLE_W-1:0] data,
  output logic [SAMPLE_W-1:0]          lane
);

  logic [SAMPLE_W-1:0] lane_d, lane_q;

  // Out-of-range sel matches no lane and loads zero.
  always_comb begin
    lane_d = lane_q;
    if (load) begin
      lane_d = '0;
      for (int k = 0; k < NUM_PATH; k++) begin
        if (sel == SEL_W'(k)) lane_d = data[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lane_q <= '0;
    else     lane_q <= lane_d;
  end

  assign lane = lane_q;

endmodule

// File: rtl/capture_rd_ctrl.sv
// MDIO readback of one capture SRAM lane sample, yielding to the write path.
module capture_rd_ctrl
  import capture_rd_pkg::*;
#(
  parameter int NUM_PATH  = NUM_PATH_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int RD_LAT    = 2
) (
  input  logic                         pktctrl_clk,
  input  logic                         pktctrl_rst,
  input  logic                         rf_mdio_read_pulse_sync,
  input  logic [SEL_W-1:0]             rf_mdio_data_sel_sync,
  input  logic [ADDR_W-1:0]            rf_mdio_memory_addr_sync,
  input  logic                         mem_busy,
  output logic                         mem_rd_req,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  input  logic [NUM_PATH*SAMPLE_W-1:0] mem_rd_data,
  output logic                         mdio_read_pulse_r,
  output logic [SAMPLE_W-1:0]          rf_mdio_pkt_data,
  output logic                         rd_err,
  output logic                         rd_overrun
);

  state_e              state_d, state_q;
  logic                pulse_dly_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic [SEL_W-1:0]    sel_d, sel_q;
  logic                ill_d, ill_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                ovr_d, ovr_q;
  logic [SAMPLE_W-1:0] data_d, data_q;
  logic                done_d, done_q;
  logic                err_d, err_q;
  logic                mux_load;
  logic [SAMPLE_W-1:0] mux_lane;
  logic                req_edge;
  logic                req_ill;

  assign req_edge = rf_mdio_read_pulse_sync & ~pulse_dly_q;
  assign req_ill  = (int'(rf_mdio_data_sel_sync) >= NUM_PATH) ||
                    (int'(rf_mdio_memory_addr_sync) >= MEM_DEPTH);

  always_ff @(posedge pktctrl_clk) begin
    if (pktctrl_rst) begin
      state_q     <= ST_IDLE;
      pulse_dly_q <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      ill_q       <= 1'b0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_dly_q <= rf_mdio_read_pulse_sync;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      ill_q       <= ill_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    ill_d    = ill_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    mux_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          addr_d  = rf_mdio_memory_addr_sync;
          sel_d   = rf_mdio_data_sel_sync;
          ill_d   = req_ill;
          state_d = req_ill ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (!mem_busy) begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          mux_load = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
    // Edges outside IDLE are dropped but remembered.
    if (req_edge && state_q != ST_IDLE) ovr_d = 1'b1;
  end

  always_comb begin
    mem_rd_req = (state_q == ST_REQ) & ~mem_busy;
    done_d     = (state_q == ST_DONE);
    err_d      = (state_q == ST_DONE) & ill_q;
    data_d     = data_q;
    if (state_q == ST_DONE) data_d = ill_q ? '0 : mux_lane;
  end

  capture_lane_mux #(
    .NUM_PATH (NUM_PATH),
    .SAMPLE_W (SAMPLE_W)
  ) u_lane_mux (
    .clk  (pktctrl_clk),
    .rst  (pktctrl_rst),
    .load (mux_load),
    .sel  (sel_q),
    .data (mem_rd_data),
    .lane (mux_lane)
  );

  assign mem_rd_addr       = addr_q;
  assign mdio_read_pulse_r = done_q;
  assign rf_mdio_pkt_data  = data_q;
  assign rd_err            = err_q;
  assign rd_overrun        = ovr_q;

endmodule

// File: tb/tb_capture_rd_ctrl.sv
// Bench for capture_rd_ctrl: directed steps plus random traffic vs a transaction model.
module tb_capture_rd_ctrl;
  import capture_rd_pkg::*;

  localparam int NP     = 96;
  localparam int SW     = 9;
  localparam int AW     = 15;
  localparam int MEM    = 32768;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse = 1'b0;
  logic          busy = 1'b0;
  logic [6:0]    sel = '0;
  logic [AW-1:0] addr = '0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [NP*SW-1:0] rd_data;
  logic          done_p;
  logic [SW-1:0] pkt;
  logic          err;
  logic          ovr;

  always #5 clk = ~clk;

  capture_rd_ctrl dut (
    .pktctrl_clk              (clk),
    .pktctrl_rst              (rst),
    .rf_mdio_read_pulse_sync  (pulse),
    .rf_mdio_data_sel_sync    (sel),
    .rf_mdio_memory_addr_sync (addr),
    .mem_busy                 (busy),
    .mem_rd_req               (rd_req),
    .mem_rd_addr              (rd_addr),
    .mem_rd_data              (rd_data),
    .mdio_read_pulse_r        (done_p),
    .rf_mdio_pkt_data         (pkt),
    .rd_err                   (err),
    .rd_overrun               (ovr)
  );

  function automatic logic [8:0] lane_val(input logic [AW-1:0] a, input int k);
    int t;
    t = (k + (int'(a) - 16) * 3) % 512;
    if (t < 0) t += 512;
    return 9'(t);
  endfunction

  // SRAM model: data for the address presented RD_LAT cycles earlier.
  logic [AW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NP; k++) rd_data[k*SW +: SW] = lane_val(pipe[RD_LAT-1], k);
  end

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int mode = 0;
  int req_start = 0;
  int done_cyc = 0;
  logic prev_p = 1'b0;
  logic [AW-1:0] lat_a = '0;
  logic [6:0] lat_s = '0;
  logic exp_err_l = 1'b0;
  logic [8:0] exp_data = '0;
  logic exp_ovr = 1'b0;

  int n_req, n_done, req_cyc, dn_cyc, n0;
  logic [AW-1:0] req_a;
  logic [8:0] dn_data;
  logic dn_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    n_req = 0; n_done = 0; req_cyc = -100; dn_cyc = -100;
    req_a = '0; dn_data = '0; dn_err = 1'b0;
  endtask

  task automatic step(input logic p, input logic b,
                      input logic [AW-1:0] a, input logic [6:0] s);
    logic exp_done, exp_rq, edge_l;
    @(negedge clk);
    pulse = p; busy = b; addr = a; sel = s;
    #1;
    cyc++;
    exp_done = (mode == 2) && (cyc == done_cyc);
    if (exp_done) exp_data = exp_err_l ? 9'd0 : lane_val(lat_a, int'(lat_s));
    chk("done_pulse", 32'(done_p), 32'(exp_done));
    chk("rd_err", 32'(err), 32'(exp_done & exp_err_l));
    chk("pkt_data", 32'(pkt), 32'(exp_data));
    chk("overrun", 32'(ovr), 32'(exp_ovr));
    exp_rq = (mode == 1) && (cyc >= req_start) && !b;
    chk("mem_rd_req", 32'(rd_req), 32'(exp_rq));
    if (exp_rq) begin
      chk("mem_rd_addr", 32'(rd_addr), 32'(lat_a));
      mode = 2;
      done_cyc = cyc + RD_LAT + 2;
    end
    if (exp_done) mode = 0;
    if (rd_req === 1'b1) begin n_req++; req_cyc = cyc; req_a = rd_addr; end
    if (done_p === 1'b1) begin n_done++; dn_cyc = cyc; dn_data = pkt; dn_err = err; end
    edge_l = p & ~prev_p;
    prev_p = p;
    if (edge_l) begin
      if (mode == 0) begin
        lat_a = a; lat_s = s;
        exp_err_l = (int'(s) >= NP) || (int'(a) >= MEM);
        if (exp_err_l) begin mode = 2; done_cyc = cyc + 2; end
        else begin mode = 1; req_start = cyc + 1; end
      end else begin
        exp_ovr = 1'b1;
      end
    end
  endtask

  task automatic run(input int n, input logic p, input logic b,
                     input logic [AW-1:0] a, input logic [6:0] s);
    for (int i = 0; i < n; i++) step(p, b, a, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pulse = 1'b0; busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc++;
    mode = 0; prev_p = 1'b0; exp_data = '0; exp_ovr = 1'b0;
    chk("rst_done", 32'(done_p), 0);
    chk("rst_data", 32'(pkt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_req", 32'(rd_req), 0);
    chk("rst_addr", 32'(rd_addr), 0);
  endtask

  initial begin
    do_reset();

    // basic read
    clear_obs();
    run(2, 0, 0, 0, 0);
    n0 = cyc + 1;
    step(1, 0, 15'h0010, 7'd5);
    run(8, 0, 0, 15'h0010, 7'd5);
    chk("basic_nreq", 32'(n_req), 1);
    chk("basic_req_lat", 32'(req_cyc - n0), 1);
    chk("basic_addr", 32'(req_a), 32'h10);
    chk("basic_done_lat", 32'(dn_cyc - n0), 5);
    chk("basic_data", 32'(dn_data), 5);
    chk("basic_err", 32'(dn_err), 0);

    // busy stall
    clear_obs();
    n0 = cyc + 1;
    step(1, 1, 15'd496, 7'd95);
    run(9, 0, 1, 15'd496, 7'd95);
    run(8, 0, 0, 15'd496, 7'd95);
    chk("busy_nreq", 32'(n_req), 1);
    chk("busy_req_lat", 32'(req_cyc - n0), 10);
    chk("busy_done_lat", 32'(dn_cyc - n0), 14);
    chk("busy_data", 32'(dn_data), 32'h1FF);

    // illegal sel
    clear_obs();
    n0 = cyc + 1;
    step(1, 0, 15'd0, 7'd96);
    run(5, 0, 0, 15'd0, 7'd96);
    chk("ill_nreq", 32'(n_req), 0);
    chk("ill_done_lat", 32'(dn_cyc - n0), 2);
    chk("ill_err", 32'(dn_err), 1);
    chk("ill_data", 32'(dn_data), 0);

    // overrun
    do_reset();
    clear_obs();
    n0 = cyc + 1;
    step(1, 0, 15'h0010, 7'd7);
    step(0, 0, 15'h0010, 7'd7);
    step(1, 0, 15'd496, 7'd3);
    run(8, 0, 0, 15'd496, 7'd3);
    chk("ovr_ndone", 32'(n_done), 1);
    chk("ovr_done_lat", 32'(dn_cyc - n0), 5);
    chk("ovr_data", 32'(dn_data), 7);
    chk("ovr_flag", 32'(ovr), 1);
    run(4, 0, 0, 0, 0);
    chk("ovr_sticky", 32'(ovr), 1);

    // held-high pulse
    clear_obs();
    run(20, 1, 0, 15'd100, 7'd10);
    run(3, 0, 0, 15'd100, 7'd10);
    chk("held_nreq", 32'(n_req), 1);
    chk("held_ndone", 32'(n_done), 1);
    chk("held_data", 32'(dn_data), 32'(lane_val(15'd100, 10)));

    // reset mid-read
    clear_obs();
    step(1, 0, 15'd200, 7'd40);
    run(2, 0, 0, 15'd200, 7'd40);
    do_reset();
    run(8, 0, 0, 15'd200, 7'd40);
    chk("midrst_ndone", 32'(n_done), 0);
    clear_obs();
    step(1, 0, 15'd300, 7'd50);
    run(8, 0, 0, 15'd300, 7'd50);
    chk("postrst_ndone", 32'(n_done), 1);
    chk("postrst_data", 32'(dn_data), 32'(lane_val(15'd300, 50)));

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic p_r, b_r;
      p_r = ($urandom_range(0, 3) == 0) ? ~pulse : pulse;
      b_r = ($urandom_range(0, 3) == 0);
      step(p_r, b_r, 15'($urandom), 7'($urandom_range(0, 100)));
    end
    run(12, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_rd_ctrl.md
Name: capture_rd_ctrl

Overview:
- Readback engine for the capture SRAM, in the packet-controller clock domain.
- Consumes the MDIO readback controls synchronised out of the control/MDIO subsystem: read pulse, lane select and memory address.
- Fetches one capture word, selects one 9-bit ADC lane sample from it, and returns `rf_mdio_pkt_data` plus `mdio_read_pulse_r`. The control subsystem then synchronises that result back to the 200 MHz register file.
- Arbitrates politely with the capture write path, which owns the single SRAM port while it is busy.

Parameters:
- NUM_PATH, 96, number of ADC lanes packed per capture word.
- SAMPLE_W, 9, bits per lane sample.
- ADDR_W, 15, capture SRAM address width.
- MEM_DEPTH, 32768, valid word count; addresses >= MEM_DEPTH are illegal.
- RD_LAT, 2, SRAM read latency in cycles from request to data (allowed range 1..7).

Ports:
- pktctrl_clk  in  1  block clock.
- pktctrl_rst  in  1  synchronous, active-high reset.
- rf_mdio_read_pulse_sync  in  1  synchronised register bit; a rising edge requests one read.
- rf_mdio_data_sel_sync  in  7  lane index, valid range 0..NUM_PATH-1.
- rf_mdio_memory_addr_sync  in  ADDR_W  capture word address.
- mem_busy  in  1  capture write path currently owns the SRAM port.
- mem_rd_req  out  1  one-cycle SRAM read strobe.
- mem_rd_addr  out  ADDR_W  SRAM read address.
- mem_rd_data  in  NUM_PATH*SAMPLE_W  SRAM read data; lane k occupies bits [k*SAMPLE_W +: SAMPLE_W].
- mdio_read_pulse_r  out  1  one-cycle strobe marking `rf_mdio_pkt_data` as updated.
- rf_mdio_pkt_data  out  SAMPLE_W  last read sample, held until the next completion.
- rd_err  out  1  one-cycle strobe, coincident with `mdio_read_pulse_r`, when sel or addr was illegal.
- rd_overrun  out  1  sticky flag: a request edge arrived while the block was not IDLE.

Behaviour:
- Reset:
  - Reset is synchronous, active-high, on `pktctrl_clk`.
  - All outputs go to 0: `rf_mdio_pkt_data` = 0, `mem_rd_addr` = 0, `rd_overrun` = 0.
  - The state machine returns to IDLE.
  - The edge-detect register loads 0. A pulse input that is still high after reset therefore counts as an edge on the first post-reset cycle.
- Reset mid-read: the read in flight is abandoned; no `mdio_read_pulse_r` is produced.
- Edge detect: `req_edge` = `rf_mdio_read_pulse_sync` & ~`pulse_d`, where `pulse_d` is registered every cycle.
- State machine IDLE -> REQ -> WAIT -> DONE -> IDLE:
  - IDLE: on `req_edge`, latch addr and sel, evaluate legality, go to REQ. An illegal request skips the SRAM access entirely and goes straight to DONE.
  - REQ: `mem_rd_req` = (state==REQ) & ~`mem_busy`. It is combinational from state and `mem_busy`. `mem_rd_addr` is the latched address, driven from the latch register.
    - While `mem_busy` = 1, stay in REQ indefinitely; there is no timeout.
    - Otherwise load the wait counter with RD_LAT-1 and go to WAIT.
  - WAIT: decrement the counter. At counter==0, `mem_rd_data` is valid in that cycle. Register the selected lane into the lane-mux output register and go to DONE.
  - DONE (one cycle):
    - Drive `rf_mdio_pkt_data` from the mux register (or 0 if the request was illegal).
    - Pulse `mdio_read_pulse_r` = 1; pulse `rd_err` if the request was illegal.
    - Return to IDLE.
- Latency: with the edge in cycle N and `mem_busy` = 0:
  - `mem_rd_req` fires in cycle N+1.
  - Data is sampled in cycle N+1+RD_LAT.
  - The lane-mux register holds the sample through cycle N+2+RD_LAT.
  - `mdio_read_pulse_r` and the updated `rf_mdio_pkt_data` are visible at the register outputs in cycle N+3+RD_LAT. This is cycle N+5 at the default RD_LAT = 2.
  - `mem_busy` stalls in REQ add exactly one cycle each.
- Illegal request: sel >= NUM_PATH or addr >= MEM_DEPTH. The legality result is latched in IDLE. The completion then comes with `rf_mdio_pkt_data` = 0 and `rd_err` = 1, with latency 2 cycles after the edge.
- Overrun:
  - A `req_edge` in REQ, WAIT or DONE is dropped and sets `rd_overrun`; only reset clears it.
  - The read in progress is unaffected.
  - An edge in the same cycle as the DONE->IDLE transition is also dropped.
- Inputs are sampled only in IDLE on the edge. Later changes to addr or sel during the read have no effect.

Decomposition:
- Package `capture_rd_pkg` holds:
  - the state enum localparams `ST_IDLE`, `ST_REQ`, `ST_WAIT`, `ST_DONE`;
  - default constants for NUM_PATH, SAMPLE_W, ADDR_W and MEM_DEPTH;
  - the width of the RD_LAT counter, 3 bits.
- One sub-module, `capture_lane_mux`:
  - a registered NUM_PATH:1 selector of SAMPLE_W-bit lanes, with a load enable;
  - out-of-range sel yields 0.

Test Plan:
- Basic read: preload word 0x0010 with lane k = k mod 512, sel=5, addr=0x0010, raise pulse at N. Expect `mem_rd_req` at N+1 with `mem_rd_addr` = 0x0010, then `mdio_read_pulse_r` at N+5 with `rf_mdio_pkt_data` = 5 and `rd_err` = 0.
- Busy stall: hold `mem_busy` = 1 for 10 cycles from N, sel=95, lane 95 = 0x1FF. Expect `mem_rd_req` exactly once at N+10 and completion at N+14 with data 0x1FF.
- Illegal sel: sel=96, addr=0. Expect no `mem_rd_req`, and at N+2 `mdio_read_pulse_r` = 1, `rd_err` = 1, data = 0.
- Overrun: a second edge at N+2 with a different addr. Expect one completion carrying the first address's data and `rd_overrun` = 1, held until reset.
- Held-high pulse: keep pulse high for 20 cycles. Expect exactly one read.
- Reset mid-read: assert `pktctrl_rst` in WAIT. Expect no completion, all outputs 0, and a new request afterwards completing normally.
